servant_uart_tx: RTL and testbench

//  Wishbone-slave 8N1 UART transmitter with a small TX FIFO.

---
 rtl/servant_uart_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_servant_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_tx.sv
// servant_uart_tx: Wishbone-slave 8N1 UART transmitter with a small TX FIFO.
//
// Firmware writes whole bytes to TXDATA. It either polls STATUS or enables the
// idle interrupt. Frames are 1 start bit, 8 data bits LSB first and 1 stop
// bit. Each bit lasts CLKS_PER_BIT clocks. Queued bytes go out back-to-back
// with no idle gap between frames.
//
// Ports
//   i_wb_clk   system clock, rising edge
//   i_wb_rst   synchronous reset, active high
//   i_wb_adr   register select: 0 = TXDATA, 1 = STATUS
//   i_wb_dat   write data (TXDATA uses [7:0]; STATUS uses [3] and [4])
//   i_wb_we    write enable
//   i_wb_cyc   bus cycle/strobe
//   o_wb_rdt   read data, valid while o_wb_ack is high, zero otherwise
//   o_wb_ack   single-cycle acknowledge
//   o_tx       serial output, idle high
//   o_irq      level interrupt: irq_en & FIFO empty & transmitter idle
//
// STATUS layout: {27'b0, irq_en, overflow, busy, empty, full}
module servant_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 278,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [BW-1:0] baud_q,     baud_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic          irq_en_q,   irq_en_d;
    logic          ack_q,      ack_d;
    logic [31:0]   rdt_q,      rdt_d;
    logic          tx_q,       tx_d;
    logic          irq_q,      irq_d;

    logic access, txdata_wr, status_wr, status_rd;
    logic fifo_empty, fifo_full, busy, baud_end;
    logic push, pop;
    logic unused_dat;

    // Only the byte lane and the two STATUS control bits carry meaning.
    assign unused_dat = ^i_wb_dat[31:8];

    assign access     = i_wb_cyc & ~ack_q;
    assign txdata_wr  = access & i_wb_we & ~i_wb_adr;
    assign status_wr  = access & i_wb_we & i_wb_adr;
    assign status_rd  = access & ~i_wb_we & i_wb_adr;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign busy       = (state_q != ST_IDLE);
    assign baud_end   = (baud_q == BAUD_LAST);

    // Transmit FSM. The pop decision feeds the FIFO so that a full FIFO
    // can accept a write on the same edge that a frame start drains it.
    always_comb begin
        pop       = 1'b0;
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO and register file.
    always_comb begin
        push       = txdata_wr & (~fifo_full | pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;

        if (push) begin
            mem_d[wr_ptr_q] = i_wb_dat[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase

        if (txdata_wr && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (status_wr && i_wb_dat[3]) begin
            overflow_d = 1'b0;
        end
        if (status_wr) begin
            irq_en_d = i_wb_dat[4];
        end
    end

    // Bus response, line driver and interrupt.
    always_comb begin
        ack_d = i_wb_cyc & ~ack_q;
        rdt_d = '0;
        if (status_rd) begin
            rdt_d = {27'b0, irq_en_q, overflow_q, busy, fifo_empty, fifo_full};
        end
        // o_tx is registered from the next-state values so that the line
        // changes on the same edge the FSM does.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        irq_d = irq_en_q & fifo_empty & ~busy;
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdt_q      <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= ack_d;
            rdt_q      <= rdt_d;
            tx_q       <= tx_d;
            irq_q      <= irq_d;
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_tx     = tx_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_servant_uart_tx.sv
// Directed testbench for servant_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_servant_uart_tx;

    logic        clk;
    logic        rst;
    logic        wb_adr;
    logic [31:0] wb_dat;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        tx;
    logic        irq;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    int          cyc_cnt = 0;
    int          last_acc = 0;

    servant_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_wb_adr(wb_adr),
        .i_wb_dat(wb_dat),
        .i_wb_we (wb_we),
        .i_wb_cyc(wb_cyc),
        .o_wb_rdt(wb_rdt),
        .o_wb_ack(wb_ack),
        .o_tx    (tx),
        .o_irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access; returns 1 ns after the acknowledging edge.
    task automatic wb(input logic adr, input logic we, input logic [31:0] dat,
                      output logic [31:0] rdt);
        int unsigned n;
        wb_adr = adr;
        wb_we  = we;
        wb_dat = dat;
        wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack && n < 8);
        chk("wb_ack", 32'(wb_ack), 32'd1);
        rdt      = wb_rdt;
        last_acc = cyc_cnt;
        wb_cyc   = 1'b0;
        wb_we    = 1'b0;
    endtask

    // Expected line level for bit slot pos (0 = start, 1..8 = data, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  burst [5];
        int          a, b, c, i;
        logic        saw_low;

        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55;

        rst = 1'b1; wb_adr = 1'b0; wb_dat = '0; wb_we = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx",  32'(tx),     32'd1);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_rdt", wb_rdt,      32'd0);
        chk("rst_irq", 32'(irq),    32'd0);
        rst = 1'b0;

        repeat (100) @(negedge clk);
        chk("idle_tx",  32'(tx),  32'd1);
        chk("idle_irq", 32'(irq), 32'd0);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("idle_status", rd, 32'h02);

        // Single frame 0xA5: line falls one edge after the access edge.
        wb(1'b0, 1'b1, 32'hA5, rd);
        chk("txdata_read_side", rd, 32'd0);
        @(negedge clk);
        chk("a5_pre_start", 32'(tx), 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("a5_bit%0d", k / 4), 32'(tx), 32'(frame_bit(8'hA5, k / 4)));
        end
        @(negedge clk);
        chk("a5_after", 32'(tx), 32'd1);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("a5_status", rd, 32'h02);

        // Burst of six writes: 0x55 fills the last slot, 0x66 is dropped.
        wb(1'b0, 1'b1, 32'h11, rd);
        a = last_acc;
        wb(1'b0, 1'b1, 32'h22, rd);
        wb(1'b0, 1'b1, 32'h33, rd);
        wb(1'b0, 1'b1, 32'h44, rd);
        wb(1'b0, 1'b1, 32'h55, rd);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("burst_full_status", rd, 32'h05);
        wb(1'b0, 1'b1, 32'h66, rd);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("burst_ovf_status", rd, 32'h0D);
        do begin
            @(negedge clk);
            i = cyc_cnt - (a + 1);
            chk($sformatf("burst_f%0d_bit%0d", i / 40, (i % 40) / 4), 32'(tx),
                32'(frame_bit(burst[i / 40], (i % 40) / 4)));
        end while (i < 199);
        @(negedge clk);
        chk("burst_after", 32'(tx), 32'd1);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("burst_end_status", rd, 32'h0A);
        saw_low = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk("dropped_not_sent", 32'(saw_low), 32'd0);

        // Interrupt enable while a frame is in flight.
        wb(1'b0, 1'b1, 32'h3C, rd);
        b = last_acc;
        wb(1'b1, 1'b1, 32'h18, rd);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("irq_en_status", rd, 32'h16);
        do @(negedge clk); while (cyc_cnt < b + 40);
        chk("irq_last_stop", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_stop_done", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        wb(1'b0, 1'b1, 32'h00, rd);
        c = last_acc;
        @(negedge clk);
        chk("irq_write_edge", 32'(irq), 32'd1);
        wb(1'b0, 1'b1, 32'hFF, rd);
        @(negedge clk);
        chk("irq_dropped", 32'(irq), 32'd0);

        // Reset in the middle of the 0x00 data bits, with 0xFF still queued.
        do @(negedge clk); while (cyc_cnt < c + 13);
        chk("mid_data_low", 32'(tx), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx",  32'(tx),  32'd1);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk("rst_no_resend", 32'(saw_low), 32'd0);
        wb(1'b1, 1'b0, 32'd0, rd);
        chk("rst_mid_status", rd, 32'h02);

        // cyc held high: ack alternates, one access per ack.
        @(posedge clk);
        #1;
        wb_adr = 1'b1; wb_we = 1'b0; wb_cyc = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("held_ack%0d", j), 32'(wb_ack), (j % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("held_rdt%0d", j), wb_rdt, (j % 2 == 1) ? 32'h02 : 32'd0);
        end
        wb_cyc = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_release", 32'(wb_ack), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
